fetch_pcu: RTL and testbench

FETCH_PCU -- requirements
Module: fetch_pcu

---
 rtl/fetch_pcu_pkg.sv | 33 +++
 rtl/pcu_jump_fifo.sv | 88 ++++++++
 rtl/fetch_pcu.sv | 112 +++++++++++
 tb/tb_fetch_pcu.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pcu_pkg.sv
// fetch_pcu_pkg: shared constants and types for the fetch program-counter unit.
//   - default address width and reset vector
//   - legal fetch widths and the word-alignment mask
//   - next-PC source select encoding
//   - elaboration helpers that validate the parameter set
package fetch_pcu_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam logic [XLEN_DEFAULT-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    localparam int FETCH_BYTES_4 = 4;
    localparam int FETCH_BYTES_8 = 8;

    // Jump and trap targets are word aligned: the low two bits are always dropped.
    localparam int ADDR_ALIGN_BITS = 2;
    localparam logic [XLEN_DEFAULT-1:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        PC_SEL_HOLD,
        PC_SEL_TRAP,
        PC_SEL_JUMP,
        PC_SEL_SEQ
    } pc_sel_e;

    function automatic logic fetch_bytes_legal(input int fb);
        return (fb == FETCH_BYTES_4) || (fb == FETCH_BYTES_8);
    endfunction

    function automatic logic depth_legal(input int d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/pcu_jump_fifo.sv
// pcu_jump_fifo: synchronous FIFO holding pending jump targets.
//   clk, reset_n   clock, async active-low reset
//   push_i/wr_data_i  write request and data (ignored when full)
//   pop_i          remove head entry (ignored when empty)
//   flush_i        empty the queue; overrides push and pop in the same cycle
//   head_o         oldest entry, valid when empty_o is low
//   count_o        occupancy, 0..DEPTH
//   full_o/empty_o occupancy flags
module pcu_jump_fifo
    import fetch_pcu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    generate
        if (!depth_legal(DEPTH)) begin : g_bad_depth
            $error("pcu_jump_fifo: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observable once counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/fetch_pcu.sv
// fetch_pcu: program-counter unit feeding the instruction fetch stage.
//   clk, reset_n     clock, async active-low reset
//   ready_i          fetch stage accepts inst_addr_o this cycle
//   jump_valid_i/jump_addr_i/jump_ready_o  queued jump redirects
//   trap_valid_i/trap_addr_i  immediate flush redirect, highest priority
//   valid_o/inst_addr_o       registered fetch address (valid every cycle)
//   jq_count_o       jump queue occupancy
// Next-PC priority: trap, then queued jump on fire, then sequential on fire,
// otherwise hold.
module fetch_pcu
    import fetch_pcu_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter int              FETCH_BYTES  = FETCH_BYTES_4,
    parameter int              JQ_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ready_i,
    input  logic                      jump_valid_i,
    input  logic [XLEN-1:0]           jump_addr_i,
    output logic                      jump_ready_o,
    input  logic                      trap_valid_i,
    input  logic [XLEN-1:0]           trap_addr_i,
    output logic                      valid_o,
    output logic [XLEN-1:0]           inst_addr_o,
    output logic [$clog2(JQ_DEPTH):0] jq_count_o
);

    generate
        if (!fetch_bytes_legal(FETCH_BYTES)) begin : g_bad_fetch_bytes
            $error("fetch_pcu: FETCH_BYTES must be 4 or 8");
        end
        if (!depth_legal(JQ_DEPTH)) begin : g_bad_jq_depth
            $error("fetch_pcu: JQ_DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    localparam logic [XLEN-1:0] WORD_MASK  = ~XLEN'(~ADDR_ALIGN_MASK);
    localparam logic [XLEN-1:0] FETCH_MASK = ~XLEN'(FETCH_BYTES - 1);
    localparam logic [XLEN-1:0] FETCH_INC  = XLEN'(FETCH_BYTES);

    logic [XLEN-1:0] addr_q, addr_d;
    logic            valid_q, valid_d;
    logic            fire;
    pc_sel_e         pc_sel;

    logic            jq_push;
    logic            jq_pop;
    logic [XLEN-1:0] jq_head;
    logic            jq_full;
    logic            jq_empty;

    assign fire = valid_q && ready_i;

    // A trap flushes the queue and swallows any jump offered in the same cycle.
    assign jq_push = jump_valid_i && !jq_full && !trap_valid_i;
    assign jq_pop  = (pc_sel == PC_SEL_JUMP);

    pcu_jump_fifo #(
        .WIDTH (XLEN),
        .DEPTH (JQ_DEPTH)
    ) u_jump_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_i    (jq_push),
        .wr_data_i (jump_addr_i & WORD_MASK),
        .pop_i     (jq_pop),
        .flush_i   (trap_valid_i),
        .head_o    (jq_head),
        .count_o   (jq_count_o),
        .full_o    (jq_full),
        .empty_o   (jq_empty)
    );

    assign jump_ready_o = !jq_full;

    always_comb begin
        pc_sel = PC_SEL_HOLD;
        if (trap_valid_i)         pc_sel = PC_SEL_TRAP;
        else if (fire && !jq_empty) pc_sel = PC_SEL_JUMP;
        else if (fire)            pc_sel = PC_SEL_SEQ;
    end

    always_comb begin
        addr_d  = addr_q;
        valid_d = 1'b1;
        case (pc_sel)
            PC_SEL_TRAP: addr_d = trap_addr_i & WORD_MASK;
            PC_SEL_JUMP: addr_d = jq_head;
            // Align down to the fetch block first so a misaligned trap target
            // resumes on the following block boundary; the add wraps at 2^XLEN.
            PC_SEL_SEQ:  addr_d = (addr_q & FETCH_MASK) + FETCH_INC;
            default:     addr_d = addr_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= RESET_VECTOR;
            valid_q <= 1'b1;
        end else begin
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    assign inst_addr_o = addr_q;
    assign valid_o     = valid_q;

endmodule

// File: tb/tb_fetch_pcu.sv
module tb_fetch_pcu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ready_i;
    logic        jump_valid_i;
    logic [31:0] jump_addr_i;
    logic        trap_valid_i;
    logic [31:0] trap_addr_i;

    logic        jr4, jr8, v4, v8;
    logic [31:0] a4, a8;
    logic [2:0]  c4, c8;

    always #5 clk = ~clk;

    fetch_pcu u_dut4 (
        .clk(clk), .reset_n(reset_n), .ready_i(ready_i),
        .jump_valid_i(jump_valid_i), .jump_addr_i(jump_addr_i), .jump_ready_o(jr4),
        .trap_valid_i(trap_valid_i), .trap_addr_i(trap_addr_i),
        .valid_o(v4), .inst_addr_o(a4), .jq_count_o(c4)
    );

    fetch_pcu #(.FETCH_BYTES(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .ready_i(ready_i),
        .jump_valid_i(jump_valid_i), .jump_addr_i(jump_addr_i), .jump_ready_o(jr8),
        .trap_valid_i(trap_valid_i), .trap_addr_i(trap_addr_i),
        .valid_o(v8), .inst_addr_o(a8), .jq_count_o(c8)
    );

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] pc8;
        logic [2:0]  cnt;
        logic        jr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_pc4, m_pc8;
    logic [31:0] m_jq[$];
    int          checks = 0;
    int          errors = 0;
    bit          started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: current PC of each instance plus the list of pending jumps.
    task automatic model_reset();
        m_pc4 = 32'h0;
        m_pc8 = 32'h0;
        m_jq.delete();
    endtask

    task automatic model_next(input bit r, input bit jv, input logic [31:0] ja,
                              input bit tv, input logic [31:0] ta);
        bit          accept;
        logic [31:0] t;
        if (tv) begin
            m_pc4 = ta & ~32'd3;
            m_pc8 = ta & ~32'd3;
            m_jq.delete();
        end else begin
            accept = jv && (m_jq.size() < 4);
            if (r) begin
                if (m_jq.size() > 0) begin
                    t = m_jq.pop_front();
                    m_pc4 = t;
                    m_pc8 = t;
                end else begin
                    m_pc4 = (m_pc4 & ~32'd3) + 32'd4;
                    m_pc8 = (m_pc8 & ~32'd7) + 32'd8;
                end
            end
            if (accept) m_jq.push_back(ja & ~32'd3);
        end
    endtask

    // One clock of stimulus: record what the DUT should show now, then apply
    // inputs and advance the model to the state after the next edge.
    task automatic cycle(input bit rst, input bit r, input bit jv, input logic [31:0] ja,
                         input bit tv, input logic [31:0] ta);
        exp_t e;
        @(posedge clk);
        #2;
        reset_n = !rst;
        if (rst) model_reset();
        e.pc4 = m_pc4;
        e.pc8 = m_pc8;
        e.cnt = 3'(m_jq.size());
        e.jr  = (m_jq.size() != 4);
        exp_q.push_back(e);
        started      = 1'b1;
        ready_i      = r;
        jump_valid_i = jv;
        jump_addr_i  = ja;
        trap_valid_i = tv;
        trap_addr_i  = ta;
        if (!rst) model_next(r, jv, ja, tv, ta);
    endtask

    // The address is presented every cycle, so the monitor checks each negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL no_expectation actual=output required=queued_entry at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("addr_fb4",   a4, e.pc4);
                    chk("addr_fb8",   a8, e.pc8);
                    chk("count_fb4",  32'(c4), 32'(e.cnt));
                    chk("count_fb8",  32'(c8), 32'(e.cnt));
                    chk("jready_fb4", 32'(jr4), 32'(e.jr));
                    chk("jready_fb8", 32'(jr8), 32'(e.jr));
                    chk("valid_fb4",  32'(v4), 32'd1);
                    chk("valid_fb8",  32'(v8), 32'd1);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        ready_i = 1'b0;
        jump_valid_i = 1'b0;
        jump_addr_i = '0;
        trap_valid_i = 1'b0;
        trap_addr_i = '0;
        model_reset();

        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        // Sequential fetch from reset vector
        repeat (5) cycle(0, 1, 0, 0, 0, 0);

        // Stall holds address
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0, 0);
        repeat (2) cycle(0, 1, 0, 0, 0, 0);

        // Two back-to-back jumps
        cycle(0, 1, 1, 32'h100, 0, 0);
        cycle(0, 1, 1, 32'h200, 0, 0);
        repeat (4) cycle(0, 1, 0, 0, 0, 0);

        // Overfill while stalled, then drain
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 32'h1000 + 32'(i) * 32'h10, 0, 0);
        repeat (6) cycle(0, 1, 0, 0, 0, 0);

        // Trap while queue holds entries, with a same-cycle jump
        cycle(0, 0, 1, 32'h500, 0, 0);
        cycle(0, 0, 1, 32'h600, 0, 0);
        cycle(0, 0, 1, 32'h700, 1, 32'h80);
        cycle(0, 0, 0, 0, 0, 0);
        repeat (2) cycle(0, 1, 0, 0, 0, 0);

        // Address wrap and misaligned targets
        cycle(0, 0, 0, 0, 1, 32'hFFFF_FFF8);
        repeat (3) cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 32'h103);
        repeat (2) cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, 32'h1237, 0, 0);
        repeat (2) cycle(0, 1, 0, 0, 0, 0);

        // Push/pop in same cycle, then trap with ready high
        cycle(0, 0, 1, 32'h3000, 0, 0);
        cycle(0, 1, 1, 32'h3100, 0, 0);
        cycle(0, 1, 1, 32'h3200, 1, 32'h4004);
        repeat (2) cycle(0, 1, 0, 0, 0, 0);

        // Reset mid-operation discards queued jumps
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'h5000 + 32'(i) * 32'h4, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        repeat (3) cycle(0, 1, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            bit          r, jv, tv, rs;
            logic [31:0] ja, ta;
            r  = ($urandom_range(0, 9) < 6);
            jv = ($urandom_range(0, 2) == 0);
            tv = ($urandom_range(0, 24) == 0);
            rs = ($urandom_range(0, 199) == 0);
            ja = $urandom;
            ta = ($urandom_range(0, 3) == 0) ? ($urandom | 32'hFFFF_FFE0) : $urandom;
            cycle(rs, r, jv, ja, tv, ta);
        end

        @(negedge clk);
        #1;
        started = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
